// File: rtl/dma_ch_apb_regif_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_ch_pkg : offsets, word indices and bit positions for one DMA channel   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dma_ch_pkg;

  localparam int NUM_WORDS     = 15;
  localparam int NUM_CHN_WORDS = 12;

  localparam logic [7:0] OFF_CMD          = 8'h00;
  localparam logic [7:0] OFF_STATUS       = 8'h04;
  localparam logic [7:0] OFF_INTREN       = 8'h08;
  localparam logic [7:0] OFF_CTRL         = 8'h0C;
  localparam logic [7:0] OFF_SRCADDR      = 8'h10;
  localparam logic [7:0] OFF_DESADDR      = 8'h18;
  localparam logic [7:0] OFF_XSIZE        = 8'h20;
  localparam logic [7:0] OFF_SRCTRANSCFG  = 8'h28;
  localparam logic [7:0] OFF_DESTRANSCFG  = 8'h2C;
  localparam logic [7:0] OFF_XADDRINC     = 8'h30;
  localparam logic [7:0] OFF_FILLVAL      = 8'h38;
  localparam logic [7:0] OFF_SRCTRIGINCFG = 8'h4C;
  localparam logic [7:0] OFF_DESTRIGINCFG = 8'h50;
  localparam logic [7:0] OFF_TRIGOUTCFG   = 8'h54;
  localparam logic [7:0] OFF_LINKADDR     = 8'h78;
  localparam logic [7:0] OFF_WRKREGPTR    = 8'h88;
  localparam logic [7:0] OFF_WRKREGVAL    = 8'h8C;
  localparam logic [7:0] OFF_ERRINFO      = 8'h90;

  // data_out word indices
  localparam int W_CMD          = 0;
  localparam int W_STATUS       = 1;
  localparam int W_INTREN       = 2;
  localparam int W_CTRL         = 3;
  localparam int W_SRCADDR      = 4;
  localparam int W_DESADDR      = 5;
  localparam int W_XSIZE        = 6;
  localparam int W_SRCTRANSCFG  = 7;
  localparam int W_DESTRANSCFG  = 8;
  localparam int W_XADDRINC     = 9;
  localparam int W_FILLVAL      = 10;
  localparam int W_SRCTRIGINCFG = 11;
  localparam int W_DESTRIGINCFG = 12;
  localparam int W_TRIGOUTCFG   = 13;
  localparam int W_LINKADDR     = 14;

  // chn_reg_in word positions, counted from the LSB end
  localparam int C_ERRINFO      = 0;
  localparam int C_LINKADDR     = 1;
  localparam int C_TRIGOUTCFG   = 2;
  localparam int C_DESTRIGINCFG = 3;
  localparam int C_SRCTRIGINCFG = 4;
  localparam int C_FILLVAL      = 5;
  localparam int C_XADDRINC     = 6;
  localparam int C_DESTRANSCFG  = 7;
  localparam int C_SRCTRANSCFG  = 8;
  localparam int C_CTRL         = 9;
  localparam int C_STATUS       = 10;
  localparam int C_CMD          = 11;

  localparam int X_XSIZE   = 0;
  localparam int X_DESADDR = 1;
  localparam int X_SRCADDR = 2;

  localparam int CMD_ENABLE  = 0;
  localparam int CMD_CLEAR   = 1;
  localparam int CMD_DISABLE = 2;
  localparam int CMD_STOP    = 3;
  localparam int CMD_PAUSE   = 4;
  localparam int CMD_RESUME  = 5;
  localparam int CMD_PULSE_W = 6;

  localparam int STAT_DONE     = 16;
  localparam int STAT_ERR      = 17;
  localparam int STAT_DISABLED = 18;
  localparam int STAT_STOPPED  = 19;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  // Configuration words that are frozen while the channel is enabled
  function automatic logic is_protected(input logic [7:0] off);
    return (off >= OFF_CTRL) && (off <= OFF_LINKADDR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_ch_apb_regif_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_ch_apb_regif_if : APB3 bus bundle with master/slave views              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface dma_ch_apb_regif_if #(
  parameter int ADDR_W = 12,
  parameter int WIDTH  = 32
) ();
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDR_W-1:0]    paddr;
  logic [WIDTH-1:0]     pwdata;
  logic [WIDTH/8-1:0]   pstrb;
  logic [WIDTH-1:0]     prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/dma_ch_apb_regif_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_apb_slv_fsm : APB3 transfer sequencer with one fixed wait state        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dma_apb_slv_fsm
  import dma_ch_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic i_psel,
  input  logic i_penable,
  output logic o_load,
  output logic o_pready,
  output logic o_commit
);

  apb_state_e r_state;
  apb_state_e w_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= APB_IDLE;
    else         r_state <= w_next;
  end

  // SETUP covers the first enable cycle (the wait state); o_load captures read data for ACCESS
  always_comb begin
    w_next   = r_state;
    o_load   = 1'b0;
    o_pready = 1'b0;
    o_commit = 1'b0;
    case (r_state)
      APB_IDLE: begin
        if (i_psel && !i_penable) w_next = APB_SETUP;
      end
      APB_SETUP: begin
        if (!i_psel) begin
          w_next = APB_IDLE;
        end else if (i_penable) begin
          w_next = APB_ACCESS;
          o_load = 1'b1;
        end
      end
      APB_ACCESS: begin
        o_pready = 1'b1;
        o_commit = i_psel && i_penable;
        w_next   = (i_psel && !i_penable) ? APB_SETUP : APB_IDLE;
      end
      default: w_next = APB_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dma_ch_apb_regif.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dma_ch_apb_regif : APB3 register front end for one DMA channel             |
// | Optional byte-lane writes with APB_PSTRB_EN.            Rev 1.0            |
// +----------------------------------------------------------------------------+
module dma_ch_apb_regif
  import dma_ch_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
) (
  input  logic                         clk,
  input  logic                         resetn,
  dma_ch_apb_regif_if.slave            apb,
  input  logic                         i_wr_en_for_updated,
  input  logic [WIDTH-1:0]             i_srcaddr_upd,
  input  logic [WIDTH-1:0]             i_desaddr_upd,
  input  logic [WIDTH-1:0]             i_xsize_upd,
  input  logic [NUM_CHN_WORDS*WIDTH-1:0] i_chn_reg_in,
  input  logic [3*WIDTH-1:0]           i_xsize_upd_in,
  input  logic [WIDTH-1:0]             i_wrkregval_in,
  output logic [NUM_WORDS*WIDTH-1:0]   o_data_out,
  output logic [WIDTH-1:0]             o_cfg_wrkregptr
);

  logic [WIDTH-1:0]     r_word [NUM_WORDS];
  logic [WIDTH-1:0]     r_ptr;
  logic [WIDTH-1:0]     r_prdata;
  logic                 r_pslverr;

  logic                 w_load;
  logic                 w_fsm_commit;
  logic                 w_pready;
  logic                 w_commit;
  logic [7:0]           w_off;
  logic                 w_hit;
  logic                 w_ro;
  logic                 w_prot;
  logic                 w_wword;
  logic                 w_wptr;
  logic [3:0]           w_widx;
  logic [WIDTH-1:0]     w_rdata;
  logic [WIDTH-1:0]     w_mask;
  logic                 w_nop;
  logic                 w_err;
  logic                 w_chn_en;
  logic [NUM_WORDS-1:0] w_we;
  logic [WIDTH-1:0]     w_cmd_merged;

  dma_apb_slv_fsm u_fsm (
    .clk       (clk),
    .resetn    (resetn),
    .i_psel    (apb.psel),
    .i_penable (apb.penable),
    .o_load    (w_load),
    .o_pready  (w_pready),
    .o_commit  (w_fsm_commit)
  );

`ifdef APB_PSTRB_EN
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < WIDTH/8; b++) w_mask[8*b +: 8] = {8{apb.pstrb[b]}};
  end
  assign w_nop = apb.pwrite && (apb.pstrb == '0);
`else
  assign w_mask = '1;
  assign w_nop  = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_v);
    return (old_v & ~w_mask) | (apb.pwdata & w_mask);
  endfunction

  assign w_off    = {apb.paddr[7:2], 2'b00};
  assign w_chn_en = i_chn_reg_in[C_CMD*WIDTH + CMD_ENABLE];

  always_comb begin
    w_hit   = 1'b0;
    w_ro    = 1'b0;
    w_wword = 1'b0;
    w_wptr  = 1'b0;
    w_widx  = 4'd0;
    w_rdata = '0;
    if (apb.paddr[ADDR_W-1:8] == '0) begin
      w_hit   = 1'b1;
      w_wword = 1'b1;
      case (w_off)
        OFF_CMD:          begin w_widx = 4'(W_CMD);          w_rdata = i_chn_reg_in[C_CMD*WIDTH +: WIDTH]; end
        OFF_STATUS:       begin w_widx = 4'(W_STATUS);       w_rdata = i_chn_reg_in[C_STATUS*WIDTH +: WIDTH]; end
        OFF_INTREN:       begin w_widx = 4'(W_INTREN);       w_rdata = r_word[W_INTREN]; end
        OFF_CTRL:         begin w_widx = 4'(W_CTRL);         w_rdata = i_chn_reg_in[C_CTRL*WIDTH +: WIDTH]; end
        OFF_SRCADDR:      begin w_widx = 4'(W_SRCADDR);      w_rdata = i_xsize_upd_in[X_SRCADDR*WIDTH +: WIDTH]; end
        OFF_DESADDR:      begin w_widx = 4'(W_DESADDR);      w_rdata = i_xsize_upd_in[X_DESADDR*WIDTH +: WIDTH]; end
        OFF_XSIZE:        begin w_widx = 4'(W_XSIZE);        w_rdata = i_xsize_upd_in[X_XSIZE*WIDTH +: WIDTH]; end
        OFF_SRCTRANSCFG:  begin w_widx = 4'(W_SRCTRANSCFG);  w_rdata = i_chn_reg_in[C_SRCTRANSCFG*WIDTH +: WIDTH]; end
        OFF_DESTRANSCFG:  begin w_widx = 4'(W_DESTRANSCFG);  w_rdata = i_chn_reg_in[C_DESTRANSCFG*WIDTH +: WIDTH]; end
        OFF_XADDRINC:     begin w_widx = 4'(W_XADDRINC);     w_rdata = i_chn_reg_in[C_XADDRINC*WIDTH +: WIDTH]; end
        OFF_FILLVAL:      begin w_widx = 4'(W_FILLVAL);      w_rdata = i_chn_reg_in[C_FILLVAL*WIDTH +: WIDTH]; end
        OFF_SRCTRIGINCFG: begin w_widx = 4'(W_SRCTRIGINCFG); w_rdata = i_chn_reg_in[C_SRCTRIGINCFG*WIDTH +: WIDTH]; end
        OFF_DESTRIGINCFG: begin w_widx = 4'(W_DESTRIGINCFG); w_rdata = i_chn_reg_in[C_DESTRIGINCFG*WIDTH +: WIDTH]; end
        OFF_TRIGOUTCFG:   begin w_widx = 4'(W_TRIGOUTCFG);   w_rdata = i_chn_reg_in[C_TRIGOUTCFG*WIDTH +: WIDTH]; end
        OFF_LINKADDR:     begin w_widx = 4'(W_LINKADDR);     w_rdata = i_chn_reg_in[C_LINKADDR*WIDTH +: WIDTH]; end
        OFF_WRKREGPTR:    begin w_wword = 1'b0; w_wptr = 1'b1; w_rdata = r_ptr; end
        OFF_WRKREGVAL:    begin w_wword = 1'b0; w_ro = 1'b1;   w_rdata = i_wrkregval_in; end
        OFF_ERRINFO:      begin w_wword = 1'b0; w_ro = 1'b1;   w_rdata = i_chn_reg_in[C_ERRINFO*WIDTH +: WIDTH]; end
        default:          begin w_wword = 1'b0; w_hit = 1'b0; end
      endcase
    end
  end

  assign w_prot = is_protected(w_off);
  assign w_err  = !w_hit || (apb.pwrite && !w_nop && (w_ro || (w_prot && w_chn_en)));

  // The error decision is frozen at load time so commit and response always agree
  assign w_commit = w_fsm_commit && apb.pwrite && !r_pslverr;

  always_comb begin
    w_we = '0;
    for (int k = 0; k < NUM_WORDS; k++)
      w_we[k] = w_commit && w_wword && (w_widx == 4'(k));
  end

  assign w_cmd_merged = f_merge(r_word[W_CMD]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_WORDS; k++) r_word[k] <= '0;
      r_ptr     <= '0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_prdata  <= (w_load && !apb.pwrite && w_hit) ? w_rdata : '0;
      r_pslverr <= w_load && w_err;

      r_word[W_CMD][CMD_PULSE_W-1:0] <= '0;
      r_word[W_STATUS]               <= '0;

      if (i_wr_en_for_updated) begin
        r_word[W_SRCADDR] <= i_srcaddr_upd;
        r_word[W_DESADDR] <= i_desaddr_upd;
        r_word[W_XSIZE]   <= i_xsize_upd;
      end

      // APB writes come last so they override a coincident write-back
      if (w_we[W_CMD])
        r_word[W_CMD] <= {w_cmd_merged[WIDTH-1:CMD_PULSE_W],
                          apb.pwdata[CMD_PULSE_W-1:0] & w_mask[CMD_PULSE_W-1:0]};
      if (w_we[W_STATUS])
        r_word[W_STATUS] <= apb.pwdata & w_mask;
      for (int k = W_INTREN; k < NUM_WORDS; k++)
        if (w_we[k]) r_word[k] <= f_merge(r_word[k]);

      if (w_commit && w_wptr) r_ptr <= f_merge(r_ptr);
    end
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_pack
    assign o_data_out[k*WIDTH +: WIDTH] = r_word[k];
  end

  assign o_cfg_wrkregptr = r_ptr;
  assign apb.prdata      = r_prdata;
  assign apb.pslverr     = r_pslverr;
  assign apb.pready      = w_pready;

endmodule
`default_nettype wire
